fifo_push_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the push port of one generic_fifo between NUM_REQ requesters.
- Uses the same valid/grant handshake on both sides: requesters present valid, the FIFO returns grant.
- Supports bursts: the winning requester keeps ownership until it marks the last beat, or until MAX_BURST beats have been transferred, whichever comes first.
- Zero-latency forwarding: requester data/valid reach the FIFO combinationally, and the FIFO grant is routed back combinationally.

---
 rtl/fifo_push_rr_arbiter.sv | 75 +++++++
 tb/tb_fifo_push_rr_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_push_rr_arbiter.sv
// fifo_push_rr_arbiter: round-robin burst arbiter that shares one FIFO push port
// between NUM_REQ requesters, with combinational data/valid/grant forwarding.
module fifo_push_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_grant_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic                          fifo_valid_o,
    input  logic                          fifo_grant_i,
    output logic [IDX_W-1:0]              owner_o,
    output logic                          busy_o
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr, owner, sel, cur, nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             found, locked, accept, release_now;
    int               idx;

    // Scan from the highest index down so the entry closest to rr_ptr wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid_i[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign locked       = (state == LOCKED);
    assign cur          = locked ? owner : sel;
    assign fifo_valid_o = locked ? req_valid_i[owner] : found;
    assign fifo_data_o  = (locked || found) ? req_data_i[cur*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign req_grant_o  = ((locked || found) && fifo_grant_i) ? (NUM_REQ'(1) << cur) : '0;
    assign accept       = fifo_valid_o && fifo_grant_i;
    assign release_now  = req_last_i[cur] ||
                          (locked ? (beat_cnt == CNT_W'(MAX_BURST - 1)) : (MAX_BURST == 1));
    assign nxt          = (cur == IDX_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
    assign busy_o       = locked;
    assign owner_o      = owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            owner <= cur;
            if (release_now) begin
                state    <= IDLE;
                rr_ptr   <= nxt;
                beat_cnt <= '0;
            end else begin
                state    <= LOCKED;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_push_rr_arbiter.sv
// tb_fifo_push_rr_arbiter: directed and random stimulus against a priority-list
// reference model, with a scoreboard monitor comparing every cycle's outputs.
module tb_fifo_push_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_valid = '0, req_last = '0, req_grant;
    logic [W-1:0] fifo_data;
    logic         fifo_valid, fifo_grant = 1'b0, busy;
    logic [1:0]   owner;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         valid;
        logic [W-1:0] data;
        logic         busy;
        logic [1:0]   owner;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0, errors = 0;

    // Model: priority order as a list, burst owner (-1 when free) and beats taken.
    int prio[$];
    int own = -1, beats = 0, last_own = 0;

    fifo_push_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_data_i(req_data), .req_valid_i(req_valid),
        .req_last_i(req_last), .req_grant_o(req_grant), .fifo_data_o(fifo_data),
        .fifo_valid_o(fifo_valid), .fifo_grant_i(fifo_grant), .owner_o(owner), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        prio = {0, 1, 2, 3};
        own = -1;
        beats = 0;
        last_own = 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic g, input bit rnd);
        obs_t e;
        int s, k, x;
        @(negedge clk);
        req_valid = v;
        req_last = l;
        fifo_grant = g;
        for (int j = 0; j < N; j++) req_data[j*W +: W] = rnd ? $urandom : 32'hA0 + j;
        #1;
        if (!rst_n) model_reset();
        s = -1;
        if (own < 0) foreach (prio[i]) if (s < 0 && v[prio[i]]) s = prio[i];
        k = (own >= 0) ? own : s;
        e.valid = (own >= 0) ? v[own] : (s >= 0);
        e.data  = (k >= 0) ? req_data[k*W +: W] : '0;
        e.grant = '0;
        if (k >= 0 && g) e.grant[k] = 1'b1;
        e.busy  = (own >= 0);
        e.owner = 2'((own >= 0) ? own : last_own);
        exp_q.push_back(e);
        if (rst_n && e.valid && g) begin
            last_own = k;
            beats = ((own >= 0) ? beats : 0) + 1;
            if (l[k] || beats == MB) begin
                own = -1;
                beats = 0;
                while (prio[$] != k) begin
                    x = prio.pop_front();
                    prio.push_back(x);
                end
            end else begin
                own = k;
            end
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{grant: req_grant, valid: fifo_valid, data: fifo_data, busy: busy, owner: owner};
                check("scoreboard", 64'(a), 64'(e));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("rst_grant", req_grant, 0);
        check("rst_valid", fifo_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_data", fifo_data, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
            check("rr_grant", req_grant, 64'(1) << (i % 4));
            check("rr_data", fifo_data, 32'hA0 + (i % 4));
        end

        cycle(4'b0110, 4'b0000, 1'b1, 1'b0);
        check("burst_b1_grant", req_grant, 4'b0010);
        cycle(4'b0110, 4'b0000, 1'b1, 1'b0);
        check("burst_b2_grant", req_grant, 4'b0010);
        check("burst_b2_busy", busy, 1);
        cycle(4'b0110, 4'b0010, 1'b1, 1'b0);
        check("burst_b3_grant", req_grant, 4'b0010);
        check("burst_b3_busy", busy, 1);
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
        check("burst_next_grant", req_grant, 4'b0100);
        check("burst_next_busy", busy, 0);
        cycle(4'b0100, 4'b0100, 1'b1, 1'b0);

        cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
        check("max_pre_grant", req_grant, 4'b1000);
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1001, 4'b1000, 1'b1, 1'b0);
            check("max_grant", req_grant, (i == 4) ? 4'b1000 : 4'b0001);
        end

        cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        check("bp_locked", busy, 1);
        repeat (3) begin
            cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
            check("bp_valid", fifo_valid, 1);
            check("bp_data", fifo_data, 32'hA0);
            check("bp_grant", req_grant, 0);
            check("bp_owner", owner, 0);
            check("bp_busy", busy, 1);
        end
        cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        check("bp_b3_busy", busy, 1);
        cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
        check("bp_b4_busy", busy, 1);
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("bp_released", busy, 0);

        cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
        check("ar_owner2", owner, 2);
        check("ar_busy_before", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_owner", owner, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(4'b0101, 4'b0000, 1'b1, 1'b0);
        check("ar_first_grant", req_grant, 4'b0001);

        repeat (3000)
            cycle(4'($urandom), 4'($urandom & $urandom), $urandom_range(0, 3) != 0, 1'b1);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
